if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipeline. It owns the PC and the IF/ID pipeline register, and issues requests to instruction memory over a req/ready handshake that tolerates variable latency. It consumes the hazard unit's `pc_write`/`ifid_write` stall controls and the ID-stage branch redirect, and it feeds the ID stage, which in turn feeds the hazard unit. It also detects HLT and freezes fetch.

## Interface
- `ADDR_W`, 16, PC / instruction-address width
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc_write`  in  1  hazard unit: 0 holds PC
- `ifid_write`  in  1  hazard unit: 0 holds IF/ID
- `branch_taken`  in  1  ID-stage redirect, final decision
- `branch_target`  in  ADDR_W  redirect address
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address; stable while `imem_req`=1 and `imem_ready`=0
- `imem_ready`  in  1  memory returns data this cycle
- `imem_rdata`  in  INSTR_W  instruction; valid only when `imem_req`&`imem_ready`
- `ifid_instr`  out  INSTR_W  IF/ID instruction
- `ifid_pc_plus2`  out  ADDR_W  IF/ID PC+2 of that instruction
- `ifid_valid`  out  1  IF/ID holds a real instruction (0 = bubble)
- `halted`  out  1  HLT fetched; fetch frozen
- `fetch_busy`  out  1  memory request outstanding and not yet returned

## Operation
- Reset (async): pc=RESET_PC, addr_q=RESET_PC, state=FETCH, hold buffer cleared, `ifid_instr`=0, `ifid_pc_plus2`=0, `ifid_valid`=0, `halted`=0. `imem_req` is forced to 0 while `rst`=1.
- `accept` = `pc_write` & `ifid_write`.
- `avail` = (FETCH & `imem_ready`) | HOLD.
- `imem_req`=1 in FETCH and DRAIN. `imem_addr`=addr_q. In FETCH, addr_q tracks pc.
- `fetch_busy` = `imem_req` & !`imem_ready`.
- A transfer completes in the cycle where req and ready are both 1. Zero-wait memory (ready in the first req cycle) is legal.
- IF/ID update priority each cycle:
  - `branch_taken` → bubble (`ifid_valid`=0, `ifid_instr`=0).
  - else `ifid_write`=0 → hold.
  - else `avail`&`accept` → load instruction (rdata or hold buffer), PC+2, valid=1.
  - else bubble.
- PC: `branch_taken` → `branch_target`. Else `avail`&`accept` → pc+2, which wraps 16'hFFFE→16'h0000. Otherwise pc is held.
- HLT = instruction[15:12]==4'hF on an accepted load.
- State machine:
  - FETCH:
    - `branch_taken`&`imem_ready` → FETCH; returned data is discarded.
    - `branch_taken`&!`imem_ready` → DRAIN; addr_q is kept at the old address.
    - `imem_ready`&`accept`&HLT → HALTED.
    - `imem_ready`&`accept` → FETCH.
    - `imem_ready`&!`accept` → HOLD; rdata is captured into the hold buffer.
    - otherwise stay in FETCH.
  - HOLD (no request):
    - `branch_taken` → FETCH; the buffer is dropped.
    - `accept`&HLT → HALTED.
    - `accept` → FETCH.
    - otherwise stay in HOLD.
  - DRAIN (old request held until it completes):
    - `imem_ready` → FETCH; data is discarded and addr_q←pc.
    - `branch_taken` updates pc only; the state remains DRAIN.
  - HALTED: `halted`=1, no request, IF/ID receives bubbles, pc frozen. `branch_taken` → FETCH with pc=`branch_target` and `halted`=0. This handles an older branch that resolves after HLT was fetched.

## Timing
- Zero-wait memory: one instruction per cycle into IF/ID. Memory with ready latency N gives one instruction per N+1 cycles, and IF/ID receives bubbles in between.
- Branch at edge t: pc=target after t. With zero-wait memory, the target instruction is in IF/ID after t+1, giving one bubble.
- Stall: when `ifid_write`=0, IF/ID and pc hold exactly. A returned instruction is parked in HOLD and is never re-requested.
- `branch_taken` overrides stall in the same cycle.
- Reset mid-request: the request is abandoned. The first post-reset request is for RESET_PC in the first cycle after `rst` falls.

## Test plan
- Zero-wait memory, no stalls, from reset: `imem_addr` sequence is 0,2,4,6. IF/ID loads with `ifid_pc_plus2`=2,4,6 on consecutive cycles and `ifid_valid`=1.
- 2-cycle-latency memory: IF/ID holds `ifid_valid`=1 for one cycle then bubbles for two. `fetch_busy`=1 on wait cycles, and `imem_addr` stays stable.
- Ready arrives while `pc_write`=`ifid_write`=0 for 3 cycles, instr 16'h1234 at addr 4:
  - no new request while stalled;
  - on release, IF/ID=16'h1234 with `ifid_pc_plus2`=6;
  - next request is addr 6.
- `branch_taken` to 16'h0040 during an outstanding request to 8 with ready 2 cycles later:
  - IF/ID bubble;
  - data for addr 8 is discarded;
  - next request is 16'h0040.
- Fetch 16'hF000 at addr 10:
  - IF/ID receives HLT with valid=1, and `halted`=1 the next cycle;
  - no requests follow and bubbles continue;
  - then `branch_taken` to 16'h0020 clears `halted` and addr 16'h0020 is requested.
- PC at 16'hFFFE, zero-wait: `ifid_pc_plus2`=16'h0000 and the next request is addr 0. Asserting `rst` mid-wait clears all outputs immediately.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, talks to
// instruction memory over a req/ready handshake of arbitrary latency, obeys
// hazard-unit stalls and ID-stage redirects, and freezes fetch on HLT.
//
// state   | meaning
// --------+----------------------------------------------------------------
// FETCH   | request at addr_q (== pc) outstanding, waiting for ready
// HOLD    | instruction returned during a stall, parked in hold_q, no request
// DRAIN   | redirected while a request was in flight; finish it, drop data
// HALTED  | HLT accepted; no requests, IF/ID bubbles, pc frozen until redirect
module if_stage #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pc_write_i,
    input  logic               ifid_write_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [ADDR_W-1:0]  ifid_pc_plus2_o,
    output logic               ifid_valid_o,
    output logic               halted_o,
    output logic               fetch_busy_o
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INSTR_W-1:0]  hold_q, hold_d;
    logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic                ifid_valid_q, ifid_valid_d;

    logic                accept;
    logic                avail;
    logic                take;
    logic                is_hlt;
    logic [INSTR_W-1:0]  fetched;
    logic [ADDR_W-1:0]   pc_plus2;

    // Shared decode: is an instruction available and will it be accepted.
    always_comb begin
        accept   = pc_write_i & ifid_write_i;
        avail    = ((state_q == S_FETCH) & imem_ready_i) | (state_q == S_HOLD);
        take     = avail & accept;
        fetched  = (state_q == S_HOLD) ? hold_q : imem_rdata_i;
        pc_plus2 = pc_q + ADDR_W'(2);
        is_hlt   = (fetched[INSTR_W-1 -: 4] == 4'hF);
    end

    // IF/ID next value: redirect bubbles, stall holds, otherwise load or bubble.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (branch_taken_i) begin
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
        end else if (!ifid_write_i) begin
            ifid_instr_d = ifid_instr_q;
        end else if (take) begin
            ifid_instr_d = fetched;
            ifid_pc_d    = pc_plus2;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
        end
    end

    // PC next value; the +2 wraps naturally at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken_i) begin
            pc_d = branch_target_i;
        end else if (take) begin
            pc_d = pc_plus2;
        end
    end

    // Fetch FSM next state, hold-buffer capture and request address.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        case (state_q)
            S_FETCH: begin
                if (branch_taken_i) begin
                    // In-flight request must complete before a new address goes out.
                    state_d = imem_ready_i ? S_FETCH : S_DRAIN;
                end else if (imem_ready_i) begin
                    if (accept) begin
                        state_d = is_hlt ? S_HALTED : S_FETCH;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = imem_rdata_i;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken_i) begin
                    state_d = S_FETCH;
                end else if (accept) begin
                    state_d = is_hlt ? S_HALTED : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_ready_i) begin
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                // An older branch resolving after HLT restarts fetch.
                if (branch_taken_i) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Entering or staying in FETCH always requests the up-to-date pc.
        if (state_d == S_FETCH) begin
            addr_d = pc_d;
        end
    end

    // State, PC, request address and hold buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Outputs; the request is suppressed combinationally while reset is held.
    always_comb begin
        imem_req_o      = !rst_i & ((state_q == S_FETCH) | (state_q == S_DRAIN));
        imem_addr_o     = addr_q;
        fetch_busy_o    = imem_req_o & !imem_ready_i;
        halted_o        = (state_q == S_HALTED);
        ifid_instr_o    = ifid_instr_q;
        ifid_pc_plus2_o = ifid_pc_q;
        ifid_valid_o    = ifid_valid_q;
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b0;
    logic        ifid_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
    logic        fetch_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:65535];

    if_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (pc_write),
        .ifid_write_i    (ifid_write),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ready_i    (imem_ready),
        .imem_rdata_i    (imem_rdata),
        .ifid_instr_o    (ifid_instr),
        .ifid_pc_plus2_o (ifid_pc_plus2),
        .ifid_valid_o    (ifid_valid),
        .halted_o        (halted),
        .fetch_busy_o    (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt_word(input int a);
        logic [15:0] w;
        w = 16'(a);
        // top nibble never 4'hF, so no accidental HLT
        return {1'b0, w[14:12], w[11:0] ^ 12'hA5C};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory answers with the word at the currently requested address.
    task automatic drive(input logic rdy, input logic pw, input logic iw,
                         input logic br, input logic [15:0] tgt);
        imem_ready    = rdy;
        pc_write      = pw;
        ifid_write    = iw;
        branch_taken  = br;
        branch_target = tgt;
        imem_rdata    = rdy ? mem[imem_addr] : 16'hDEAD;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] s_instr, s_pc, prev_addr, tgt;
        logic        s_valid, req_now, prev_wait, rdy, pw, iw, br;
        int          loads;

        for (int i = 0; i < 65536; i++) mem[i] = dflt_word(i);
        mem[4] = 16'h1234;

        // ---------------- reset state
        #2 rst = 1'b1;
        cyc();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", ifid_valid, 1'b0);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_pc2", ifid_pc_plus2, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, 16'h0000);

        // ---------------- zero-wait streaming 0,2,4,6
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
            cyc();
            chk("zw_valid", ifid_valid, 1'b1);
            chk("zw_pc2", ifid_pc_plus2, 16'(2 * k));
            chk("zw_instr", ifid_instr, mem[16'(2 * k - 2)]);
            chk("zw_addr", imem_addr, 16'(2 * k));
        end

        // ---------------- 2-cycle latency memory, two rounds from addr 6
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 2; w++) begin
                drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
                chk("lat_busy", fetch_busy, 1'b1);
                cyc();
                chk("lat_bubble", ifid_valid, 1'b0);
                chk("lat_addr_stable", imem_addr, 16'(6 + 2 * r));
            end
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
            chk("lat_busy_done", fetch_busy, 1'b0);
            cyc();
            chk("lat_valid", ifid_valid, 1'b1);
            chk("lat_pc2", ifid_pc_plus2, 16'(8 + 2 * r));
            chk("lat_instr", ifid_instr, mem[16'(6 + 2 * r)]);
        end

        // ---------------- stall while data returns (1234 at addr 4)
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
            cyc();
        end
        chk("stl_pre_addr", imem_addr, 16'h0004);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
            cyc();
            chk("stl_no_req", imem_req, 1'b0);
            chk("stl_hold_pc2", ifid_pc_plus2, 16'h0004);
            chk("stl_hold_instr", ifid_instr, mem[2]);
            chk("stl_hold_valid", ifid_valid, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        chk("stl_rel_instr", ifid_instr, 16'h1234);
        chk("stl_rel_pc2", ifid_pc_plus2, 16'h0006);
        chk("stl_rel_valid", ifid_valid, 1'b1);
        chk("stl_next_req", imem_req, 1'b1);
        chk("stl_next_addr", imem_addr, 16'h0006);

        // ---------------- branch during outstanding request to 8
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        chk("br_pre_addr", imem_addr, 16'h0008);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040);
        cyc();
        chk("br_bubble", ifid_valid, 1'b0);
        chk("br_bubble_instr", ifid_instr, 16'h0000);
        chk("br_drain_addr", imem_addr, 16'h0008);
        chk("br_drain_req", imem_req, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        chk("br_drain_addr2", imem_addr, 16'h0008);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        chk("br_discard", ifid_valid, 1'b0);
        chk("br_target_addr", imem_addr, 16'h0040);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        chk("br_tgt_valid", ifid_valid, 1'b1);
        chk("br_tgt_pc2", ifid_pc_plus2, 16'h0042);
        chk("br_tgt_instr", ifid_instr, mem[16'h0040]);

        // ---------------- HLT at addr 10
        do_reset();
        mem[10] = 16'hF000;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
            cyc();
        end
        chk("hlt_pre_addr", imem_addr, 16'h000A);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        chk("hlt_instr", ifid_instr, 16'hF000);
        chk("hlt_valid", ifid_valid, 1'b1);
        chk("hlt_pc2", ifid_pc_plus2, 16'h000C);
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_no_req", imem_req, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
            cyc();
            chk("hlt_bubble", ifid_valid, 1'b0);
            chk("hlt_still_no_req", imem_req, 1'b0);
            chk("hlt_still_halted", halted, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020);
        cyc();
        chk("hlt_cleared", halted, 1'b0);
        chk("hlt_restart_req", imem_req, 1'b1);
        chk("hlt_restart_addr", imem_addr, 16'h0020);
        mem[10] = dflt_word(10);

        // ---------------- PC wrap at 16'hFFFE, then reset mid-wait
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFE);
        cyc();
        chk("wrap_addr", imem_addr, 16'hFFFE);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        chk("wrap_pc2", ifid_pc_plus2, 16'h0000);
        chk("wrap_valid", ifid_valid, 1'b1);
        chk("wrap_instr", ifid_instr, mem[16'hFFFE]);
        chk("wrap_next_addr", imem_addr, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("mid_busy", fetch_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_busy", fetch_busy, 1'b0);
        chk("mid_rst_valid", ifid_valid, 1'b0);
        chk("mid_rst_instr", ifid_instr, 16'h0000);
        chk("mid_rst_pc2", ifid_pc_plus2, 16'h0000);
        chk("mid_rst_halted", halted, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_first_addr", imem_addr, 16'h0000);

        // ---------------- randomized run against a program-order stream model
        exp_pc    = 16'h0000;
        prev_wait = 1'b0;
        prev_addr = 16'h0000;
        loads     = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 2) != 0);
            pw  = 1'b1;
            iw  = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin pw = 1'b0; iw = 1'b0; end
                    1: begin pw = 1'b1; iw = 1'b0; end
                    default: begin pw = 1'b0; iw = 1'b1; end
                endcase
            end
            br  = ($urandom_range(0, 15) == 0);
            tgt = 16'($urandom) & 16'hFFFE;

            req_now = imem_req;
            if (prev_wait) begin
                chk("rnd_req_kept", imem_req, 1'b1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            s_instr = ifid_instr;
            s_pc    = ifid_pc_plus2;
            s_valid = ifid_valid;
            prev_addr = imem_addr;

            drive(rdy, pw, iw, br, tgt);
            chk("rnd_busy", fetch_busy, req_now & !rdy);
            cyc();

            if (br) begin
                chk("rnd_br_bubble", ifid_valid, 1'b0);
                exp_pc = tgt;
            end else if (!iw) begin
                chk("rnd_stall_instr", ifid_instr, s_instr);
                chk("rnd_stall_pc2", ifid_pc_plus2, s_pc);
                chk("rnd_stall_valid", ifid_valid, s_valid);
            end else if (ifid_valid) begin
                chk("rnd_load_instr", ifid_instr, mem[exp_pc]);
                chk("rnd_load_pc2", ifid_pc_plus2, exp_pc + 16'd2);
                exp_pc = exp_pc + 16'd2;
                loads++;
            end
            chk("rnd_not_halted", halted, 1'b0);
            prev_wait = req_now & !rdy;
        end
        chk("rnd_progress", (loads >= 300), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
